// File: rtl/int8_mlp_pkg.sv
// Shared types for the INT8 MLP datapath: activation type and loader bank states.
package int8_mlp_pkg;

  typedef logic signed [7:0] int8_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    ACTIVE = 2'd2
  } bank_state_t;

endpackage

// File: rtl/int8_vec_bank.sv
// IN x int8 register file: one indexed write port, asynchronous clear, parallel read.
module int8_vec_bank
  import int8_mlp_pkg::*;
#(
  parameter int IN    = 8,
  parameter int IDX_W = $clog2(IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        idx,
  input  logic signed [7:0]       din,
  output logic signed [7:0]       dout [IN]
);

  int8_t mem [IN];

  // Element storage; cleared to zero on reset so x reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < IN; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= din;
    end
  end

  assign dout = mem;

endmodule

// File: rtl/int8_vec_loader.sv
// Byte-serial INT8 activation loader with ping-pong banks feeding the FC stage.
module int8_vec_loader
  import int8_mlp_pkg::*;
#(
  parameter int IN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic signed [7:0] s_data,
  input  logic              s_last,
  output logic              start,
  output logic signed [7:0] x [IN],
  input  logic              fc_done,
  output logic              busy,
  output logic              frame_err
);

  localparam int IDX_W = $clog2(IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

  bank_state_t       state_q [2];
  bank_state_t       state_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;

  logic              hs;
  logic              at_last;
  logic              complete;
  logic              ferr;
  logic              any_active;
  logic              release_bank;

  int8_t             b0_data [IN];
  int8_t             b1_data [IN];

  assign s_ready      = (state_q[wr_bank_q] == EMPTY);
  assign hs           = s_valid && s_ready;
  assign at_last      = (wr_idx_q == LAST_IDX);
  assign complete     = hs && at_last && s_last;
  assign ferr         = hs && (s_last != at_last);
  assign any_active   = (state_q[0] == ACTIVE) || (state_q[1] == ACTIVE);
  // The ACTIVE bank is always rd_bank: rd_bank only moves when it becomes ACTIVE.
  assign release_bank = fc_done && (state_q[rd_bank_q] == ACTIVE);

  int8_vec_bank #(.IN(IN), .IDX_W(IDX_W)) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (hs && !wr_bank_q),
    .idx   (wr_idx_q),
    .din   (s_data),
    .dout  (b0_data)
  );

  int8_vec_bank #(.IN(IN), .IDX_W(IDX_W)) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (hs && wr_bank_q),
    .idx   (wr_idx_q),
    .din   (s_data),
    .dout  (b1_data)
  );

  // Fill, completion, framing, release and dispatch decisions for the next edge.
  always_comb begin
    logic disp_ok;
    logic disp_bank;
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    frame_err_d = ferr;
    disp_ok     = 1'b0;
    disp_bank   = 1'b0;

    if (hs) begin
      wr_idx_d = (complete || ferr) ? '0 : wr_idx_q + 1'b1;
    end

    if (complete) begin
      state_d[wr_bank_q] = FULL;
      wr_bank_d          = ~wr_bank_q;
    end

    if (release_bank) begin
      state_d[rd_bank_q] = EMPTY;
      busy_d             = 1'b0;
    end

    // Dispatch looks at the pre-release state, so a release forces an idle cycle.
    // Between completions wr_bank is the older bank; during a completion it is the newer.
    if (!any_active) begin
      if (complete) begin
        disp_ok   = 1'b1;
        disp_bank = (state_q[~wr_bank_q] == FULL) ? ~wr_bank_q : wr_bank_q;
      end else if (state_q[wr_bank_q] == FULL) begin
        disp_ok   = 1'b1;
        disp_bank = wr_bank_q;
      end else if (state_q[~wr_bank_q] == FULL) begin
        disp_ok   = 1'b1;
        disp_bank = ~wr_bank_q;
      end
    end

    if (disp_ok) begin
      state_d[disp_bank] = ACTIVE;
      rd_bank_d          = disp_bank;
      start_d            = 1'b1;
      busy_d             = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Vector output follows the bank selected at the last dispatch.
  always_comb begin
    for (int unsigned i = 0; i < IN; i++) begin
      x[i] = rd_bank_q ? b1_data[i] : b0_data[i];
    end
  end

  assign start     = start_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_int8_vec_loader.sv
// Directed self-checking bench for int8_vec_loader with a mock FC.
module tb_int8_vec_loader;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic signed [7:0] s_data;
  logic              s_last;
  logic              start;
  logic signed [7:0] x [8];
  logic              fc_done;
  logic              busy;
  logic              frame_err;

  logic              fc_mock;
  logic              fc_force;
  logic              mock_en;
  int                mock_cnt;

  int                total;
  int                passed;
  int                fails;

  logic [63:0]       starts_q [$];
  int                overlap;
  logic              saw_nready;

  assign fc_done = fc_mock | fc_force;

  int8_vec_loader #(.IN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .start     (start),
    .x         (x),
    .fc_done   (fc_done),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] xpack();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = x[i];
    return r;
  endfunction

  // Mock FC: done is high for the 8th cycle after the start cycle.
  initial begin
    fc_mock  = 1'b0;
    mock_cnt = 0;
    forever begin
      @(negedge clk);
      fc_mock = 1'b0;
      if (mock_cnt > 0) begin
        mock_cnt = mock_cnt - 1;
        if (mock_cnt == 0) fc_mock = 1'b1;
      end
      if (!rst_n || !busy) mock_cnt = 0;
      if (start && mock_en) mock_cnt = 8;
    end
  end

  // Observer: vectors presented at start, start/done overlap, back-pressure seen.
  initial begin
    overlap    = 0;
    saw_nready = 1'b0;
    forever begin
      @(negedge clk);
      if (start) starts_q.push_back(xpack());
      if (start && fc_done) overlap = overlap + 1;
      if (rst_n && !s_ready) saw_nready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", {63'd0, s_ready}, 64'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [7:0] base);
    for (int i = 0; i < 8; i++) send_byte(base + 8'(i), i == 7);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("idle_wait", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n;
    total    = 0;
    passed   = 0;
    fails    = 0;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    fc_force = 1'b0;
    mock_en  = 1'b1;

    // Reset state
    #12;
    chk("rst_start", {63'd0, start}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ferr", {63'd0, frame_err}, 64'd0);
    chk("rst_x", xpack(), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {63'd0, s_ready}, 64'd1);
    tick();

    // Single vector 1..8
    send_vec(8'd1);
    chk("single_start", {63'd0, start}, 64'd1);
    chk("single_busy", {63'd0, busy}, 64'd1);
    chk("single_x", xpack(), 64'h0807060504030201);
    tick();
    chk("single_start_pulse", {63'd0, start}, 64'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("single_busy_hold", {63'd0, busy}, 64'd1);
    chk("single_x_stable", xpack(), 64'h0807060504030201);
    tick();
    chk("single_busy_fall", {63'd0, busy}, 64'd0);
    tick();

    // Back-to-back vectors k = 0, 10, 20
    starts_q.delete();
    overlap    = 0;
    saw_nready = 1'b0;
    send_vec(8'd0);
    send_vec(8'd10);
    send_vec(8'd20);
    n = 0;
    while ((starts_q.size() < 3 || busy) && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_count", 64'(starts_q.size()), 64'd3);
    chk("b2b_v0", starts_q[0], 64'h0706050403020100);
    chk("b2b_v1", starts_q[1], 64'h11100F0E0D0C0B0A);
    chk("b2b_v2", starts_q[2], 64'h1B1A191817161514);
    chk("b2b_overlap", 64'(overlap), 64'd0);
    chk("b2b_backpressure", {63'd0, saw_nready}, 64'd1);
    tick();

    // Early last on byte 5
    for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
    chk("early_ferr", {63'd0, frame_err}, 64'd1);
    chk("early_nostart", {63'd0, start}, 64'd0);
    tick();
    chk("early_ferr_pulse", {63'd0, frame_err}, 64'd0);
    send_vec(8'h80);
    chk("early_next_start", {63'd0, start}, 64'd1);
    chk("early_next_x", xpack(), 64'h8786858483828180);
    wait_idle();

    // Missing last on byte 8
    for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i), 1'b0);
    chk("miss_ferr", {63'd0, frame_err}, 64'd1);
    chk("miss_nostart", {63'd0, start}, 64'd0);
    chk("miss_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("miss_nostart2", {63'd0, start}, 64'd0);
    send_vec(8'h40);
    chk("miss_next_start", {63'd0, start}, 64'd1);
    chk("miss_next_x", xpack(), 64'h4746454443424140);
    wait_idle();

    // Spurious fc_done while idle
    mock_en  = 1'b0;
    fc_force = 1'b1;
    tick();
    fc_force = 1'b0;
    chk("spur_busy", {63'd0, busy}, 64'd0);
    chk("spur_start", {63'd0, start}, 64'd0);
    chk("spur_ready", {63'd0, s_ready}, 64'd1);
    chk("spur_x", xpack(), 64'h4746454443424140);
    tick();
    chk("spur_start2", {63'd0, start}, 64'd0);

    // fc_done on the same edge as a completion
    send_vec(8'h50);
    chk("cdone_a_start", {63'd0, start}, 64'd1);
    for (int i = 0; i < 7; i++) send_byte(8'h60 + 8'(i), 1'b0);
    fc_force = 1'b1;
    send_byte(8'h67, 1'b1);
    fc_force = 1'b0;
    chk("cdone_nostart", {63'd0, start}, 64'd0);
    chk("cdone_busy_low", {63'd0, busy}, 64'd0);
    chk("cdone_ready", {63'd0, s_ready}, 64'd1);
    tick();
    chk("cdone_start", {63'd0, start}, 64'd1);
    chk("cdone_busy", {63'd0, busy}, 64'd1);
    chk("cdone_x", xpack(), 64'h6766656463626160);
    fc_force = 1'b1;
    tick();
    fc_force = 1'b0;
    chk("cdone_release", {63'd0, busy}, 64'd0);
    tick();
    chk("cdone_idle", {63'd0, start}, 64'd0);

    // Reset mid-fill
    mock_en = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'h70 + 8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rfill_start", {63'd0, start}, 64'd0);
    chk("rfill_busy", {63'd0, busy}, 64'd0);
    chk("rfill_ferr", {63'd0, frame_err}, 64'd0);
    chk("rfill_x", xpack(), 64'd0);
    chk("rfill_ready", {63'd0, s_ready}, 64'd1);
    #1;
    rst_n = 1'b1;
    send_vec(8'h11);
    chk("rfill_next_start", {63'd0, start}, 64'd1);
    chk("rfill_next_x", xpack(), 64'h1817161514131211);

    // Reset mid-compute
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rcomp_busy", {63'd0, busy}, 64'd0);
    chk("rcomp_start", {63'd0, start}, 64'd0);
    chk("rcomp_x", xpack(), 64'd0);
    chk("rcomp_ready", {63'd0, s_ready}, 64'd1);
    #1;
    rst_n = 1'b1;
    tick();
    send_vec(8'h21);
    chk("rcomp_next_start", {63'd0, start}, 64'd1);
    chk("rcomp_next_x", xpack(), 64'h2827262524232221);
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
